// File: rtl/jtl_sched_pkg.sv
package jtl_sched_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_EARLY    = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_SPURIOUS = 2'd3
  } err_code_e;

  // Timestamp width wide enough that the oldest live age can never alias.
  function automatic int unsigned ts_width(input int unsigned dly, input int unsigned slack);
    return $clog2(dly + slack + 2) + 1;
  endfunction

endpackage

// File: rtl/jtl_ts_fifo.sv
module jtl_ts_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_pop  = pop && (count != '0);
    // Push while full is legal only when the head leaves in the same cycle.
    do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
  end

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/jtl_line_scheduler.sv
module jtl_line_scheduler
  import jtl_sched_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned CT_CYC       = 2,
  parameter int unsigned DLY_CYC      = 3,
  parameter int unsigned SLACK_CYC    = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned ERRCNT_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REQ-1:0]                req,
  output logic [N_REQ-1:0]                gnt,
  output logic                            line_tgl,
  input  logic                            line_ret_tgl,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err,
  output logic [1:0]                      err_code,
  input  logic                            err_clr,
  output logic [ERRCNT_W-1:0]             viol_cnt
);

  localparam int unsigned TS_W  = ts_width(DLY_CYC, SLACK_CYC);
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HO_W  = (CT_CYC > 1) ? $clog2(CT_CYC) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [TS_W-1:0] DLY_AGE = TS_W'(DLY_CYC);
  localparam logic [TS_W-1:0] TO_AGE  = TS_W'(DLY_CYC + SLACK_CYC + 1);

  logic [TS_W-1:0]  ts_cnt;
  logic [TS_W-1:0]  head_ts;
  logic [TS_W-1:0]  age;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W:0]   scan;
  logic [N_REQ-1:0] grant_vec;
  logic [HO_W-1:0]  holdoff;
  logic             found;
  logic             grant_ok;
  logic             ret_q;
  logic             ret_edge;
  logic             nonempty;
  logic             timeout;
  logic             pop;
  logic             fault;
  err_code_e        fault_code;
  err_code_e        err_code_q;

  always_comb begin
    found     = 1'b0;
    grant_idx = rr_ptr;
    scan      = '0;
    grant_vec = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(N_REQ)) scan = scan - (PTR_W+1)'(N_REQ);
      if (!found && req[scan[PTR_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = scan[PTR_W-1:0];
      end
    end
    grant_ok = found && (holdoff == '0) && (inflight < CNT_W'(MAX_INFLIGHT)) && !err;
    if (grant_ok) grant_vec[grant_idx] = 1'b1;
  end

  always_comb begin
    ret_edge   = (line_ret_tgl != ret_q);
    nonempty   = (inflight != '0);
    age        = ts_cnt - head_ts;
    timeout    = nonempty && (age >= TO_AGE);
    // A return coinciding with a timeout retires that same head; it stays a TIMEOUT.
    pop        = nonempty && (timeout || ret_edge);
    fault      = 1'b0;
    fault_code = ERR_NONE;
    if (timeout) begin
      fault      = 1'b1;
      fault_code = ERR_TIMEOUT;
    end else if (ret_edge && !nonempty) begin
      fault      = 1'b1;
      fault_code = ERR_SPURIOUS;
    end else if (ret_edge && (age < DLY_AGE)) begin
      fault      = 1'b1;
      fault_code = ERR_EARLY;
    end
  end

  // Timestamp names the cycle in which gnt/line_tgl become visible.
  jtl_ts_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (TS_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant_ok),
    .pop   (pop),
    .din   (ts_cnt + 1'b1),
    .head  (head_ts),
    .count (inflight)
  );

  assign err_code = err_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt     <= '0;
      ret_q      <= 1'b0;
      gnt        <= '0;
      line_tgl   <= 1'b0;
      holdoff    <= '0;
      rr_ptr     <= '0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
      viol_cnt   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      ret_q  <= line_ret_tgl;
      gnt    <= grant_vec;
      if (grant_ok) begin
        line_tgl <= ~line_tgl;
        holdoff  <= HO_W'(CT_CYC - 1);
        rr_ptr   <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else if (holdoff != '0) begin
        holdoff <= holdoff - 1'b1;
      end
      if (fault) begin
        err <= 1'b1;
        if (!err || err_clr) err_code_q <= fault_code;
        if (viol_cnt != '1) viol_cnt <= viol_cnt + 1'b1;
      end else if (err_clr) begin
        err        <= 1'b0;
        err_code_q <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_jtl_line_scheduler.sv
module tb_jtl_line_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req1;
  logic       err_clr, clr1;
  logic       line_ret_tgl, ret1;
  logic [3:0] gnt, gnt1;
  logic       line_tgl, line_tgl1;
  logic [2:0] inflight, inflight1;
  logic       err, err1;
  logic [1:0] err_code, err_code1;
  logic [7:0] viol_cnt, viol_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtl_line_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .gnt          (gnt),
    .line_tgl     (line_tgl),
    .line_ret_tgl (line_ret_tgl),
    .inflight     (inflight),
    .err          (err),
    .err_code     (err_code),
    .err_clr      (err_clr),
    .viol_cnt     (viol_cnt)
  );

  jtl_line_scheduler #(
    .CT_CYC (1)
  ) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req1),
    .gnt          (gnt1),
    .line_tgl     (line_tgl1),
    .line_ret_tgl (ret1),
    .inflight     (inflight1),
    .err          (err1),
    .err_code     (err_code1),
    .err_clr      (clr1),
    .viol_cnt     (viol_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = '0; req1 = '0; err_clr = 1'b0; clr1 = 1'b0;
    line_ret_tgl = 1'b0; ret1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = '0; req1 = '0; err_clr = 1'b0; clr1 = 1'b0;
    line_ret_tgl = 1'b0; ret1 = 1'b0;
    #3;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b want=0000", gnt); end
    total++; if (line_tgl !== 1'b0) begin bad++; $display("FAIL rst_tgl got=%b want=0", line_tgl); end
    total++; if (inflight !== 3'd0) begin bad++; $display("FAIL rst_inflight got=%0d want=0", inflight); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL rst_code got=%0d want=0", err_code); end
    total++; if (viol_cnt !== 8'd0) begin bad++; $display("FAIL rst_viol got=%0d want=0", viol_cnt); end
    total++; if (inflight1 !== 3'd0 || gnt1 !== 4'b0000) begin bad++; $display("FAIL rst_dut1 got=%0d/%b want=0/0000", inflight1, gnt1); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] one, eg;
    int launches, retired;
    one = 4'b0001;
    do_reset();
    req = 4'b1111;
    for (int k = 1; k <= 10; k++) begin
      tick();
      eg = ((k % 2 == 1) && (k <= 7)) ? (one << ((k - 1) / 2)) : 4'b0000;
      launches = (k >= 7) ? 4 : (k + 1) / 2;
      retired  = (k <= 4) ? 0 : (k - 3) / 2;
      total++; if (gnt !== eg) begin bad++; $display("FAIL rr_gnt k=%0d got=%b want=%b", k, gnt, eg); end
      total++; if (line_tgl !== launches[0]) begin bad++; $display("FAIL rr_tgl k=%0d got=%b want=%b", k, line_tgl, launches[0]); end
      total++; if (inflight !== 3'(launches - retired)) begin bad++; $display("FAIL rr_inflight k=%0d got=%0d want=%0d", k, inflight, launches - retired); end
      req = req & ~eg;
      if (k == 4 || k == 6 || k == 8 || k == 10) line_ret_tgl = ~line_ret_tgl;
    end
    tick();
    total++; if (inflight !== 3'd0) begin bad++; $display("FAIL rr_end_inflight got=%0d want=0", inflight); end
    total++; if (viol_cnt !== 8'd0 || err !== 1'b0) begin bad++; $display("FAIL rr_end_viol got=%0d/%b want=0/0", viol_cnt, err); end
  endtask

  task automatic test_timeout();
    logic [3:0] eg;
    int launches, retired, ev;
    do_reset();
    req1 = 4'b0001;
    for (int k = 1; k <= 11; k++) begin
      tick();
      eg       = (k <= 4) ? 4'b0001 : 4'b0000;
      launches = (k <= 4) ? k : 4;
      retired  = (k <= 7) ? 0 : k - 7;
      ev       = retired;
      total++; if (gnt1 !== eg) begin bad++; $display("FAIL to_gnt k=%0d got=%b want=%b", k, gnt1, eg); end
      total++; if (inflight1 !== 3'(launches - retired)) begin bad++; $display("FAIL to_inflight k=%0d got=%0d want=%0d", k, inflight1, launches - retired); end
      total++; if (viol_cnt1 !== 8'(ev)) begin bad++; $display("FAIL to_viol k=%0d got=%0d want=%0d", k, viol_cnt1, ev); end
      total++; if (err1 !== (k >= 8)) begin bad++; $display("FAIL to_err k=%0d got=%b want=%b", k, err1, (k >= 8)); end
      total++; if (err_code1 !== ((k >= 8) ? 2'd2 : 2'd0)) begin bad++; $display("FAIL to_code k=%0d got=%0d want=%0d", k, err_code1, (k >= 8) ? 2 : 0); end
    end
    req1 = '0;
  endtask

  task automatic test_early();
    do_reset();
    req = 4'b0001;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL early_gnt got=%b want=0001", gnt); end
    req = '0;
    tick();
    line_ret_tgl = ~line_ret_tgl;
    tick();
    total++; if (err !== 1'b1 || err_code !== 2'd1) begin bad++; $display("FAIL early_code got=%b/%0d want=1/1", err, err_code); end
    total++; if (viol_cnt !== 8'd1 || inflight !== 3'd0) begin bad++; $display("FAIL early_viol got=%0d/%0d want=1/0", viol_cnt, inflight); end
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL early_block k=%0d got=%b want=0000", k, gnt); end
    end
    err_clr = 1'b1;
    line_ret_tgl = ~line_ret_tgl;
    tick();
    err_clr = 1'b0;
    total++; if (err !== 1'b1 || err_code !== 2'd3) begin bad++; $display("FAIL clr_vs_fault got=%b/%0d want=1/3", err, err_code); end
    total++; if (viol_cnt !== 8'd2 || gnt !== 4'b0000) begin bad++; $display("FAIL clr_vs_fault_viol got=%0d/%b want=2/0000", viol_cnt, gnt); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++; if (err !== 1'b0 || err_code !== 2'd0 || gnt !== 4'b0000) begin bad++; $display("FAIL early_clr got=%b/%0d/%b want=0/0/0000", err, err_code, gnt); end
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL early_resume got=%b want=0001", gnt); end
    req = '0;
    repeat (3) tick();
    line_ret_tgl = ~line_ret_tgl;
    tick();
    total++; if (inflight !== 3'd0 || err !== 1'b0 || viol_cnt !== 8'd2) begin bad++; $display("FAIL early_end got=%0d/%b/%0d want=0/0/2", inflight, err, viol_cnt); end
  endtask

  task automatic test_spurious();
    do_reset();
    tick();
    line_ret_tgl = ~line_ret_tgl;
    tick();
    total++; if (err !== 1'b1 || err_code !== 2'd3) begin bad++; $display("FAIL spur_code got=%b/%0d want=1/3", err, err_code); end
    total++; if (viol_cnt !== 8'd1 || inflight !== 3'd0) begin bad++; $display("FAIL spur_viol got=%0d/%0d want=1/0", viol_cnt, inflight); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    req = 4'b0010;
    total++; if (err !== 1'b0 || err_code !== 2'd0) begin bad++; $display("FAIL spur_clr got=%b/%0d want=0/0", err, err_code); end
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL spur_resume got=%b want=0010", gnt); end
    req = '0;
    repeat (3) tick();
    line_ret_tgl = ~line_ret_tgl;
    tick();
    total++; if (inflight !== 3'd0 || viol_cnt !== 8'd1 || err !== 1'b0) begin bad++; $display("FAIL spur_end got=%0d/%0d/%b want=0/1/0", inflight, viol_cnt, err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0001;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL b2b_gnt_a got=%b want=0001", gnt); end
    req = '0;
    repeat (3) tick();
    line_ret_tgl = ~line_ret_tgl;
    req = 4'b0010;
    total++; if (inflight !== 3'd1) begin bad++; $display("FAIL b2b_inflight_pre got=%0d want=1", inflight); end
    tick();
    req = '0;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL b2b_gnt_b got=%b want=0010", gnt); end
    total++; if (inflight !== 3'd1 || err !== 1'b0) begin bad++; $display("FAIL b2b_inflight got=%0d/%b want=1/0", inflight, err); end
    repeat (3) tick();
    line_ret_tgl = ~line_ret_tgl;
    tick();
    total++; if (inflight !== 3'd0 || viol_cnt !== 8'd0) begin bad++; $display("FAIL b2b_end got=%0d/%0d want=0/0", inflight, viol_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1111;
    tick();
    req = 4'b1110;
    tick();
    tick();
    req = 4'b1100;
    total++; if (gnt !== 4'b0010 || inflight !== 3'd2) begin bad++; $display("FAIL ar_pre got=%b/%0d want=0010/2", gnt, inflight); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000 || line_tgl !== 1'b0) begin bad++; $display("FAIL ar_gnt got=%b/%b want=0000/0", gnt, line_tgl); end
    total++; if (inflight !== 3'd0 || err !== 1'b0 || viol_cnt !== 8'd0) begin bad++; $display("FAIL ar_state got=%0d/%b/%0d want=0/0/0", inflight, err, viol_cnt); end
    req = '0;
    #2;
    rst_n = 1'b1;
    tick();
    line_ret_tgl = ~line_ret_tgl;
    tick();
    total++; if (err !== 1'b1 || err_code !== 2'd3 || viol_cnt !== 8'd1) begin bad++; $display("FAIL ar_late got=%b/%0d/%0d want=1/3/1", err, err_code, viol_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; req1 = '0; err_clr = 1'b0; clr1 = 1'b0;
    line_ret_tgl = 1'b0; ret1 = 1'b0;
    test_reset();
    test_round_robin();
    test_timeout();
    test_early();
    test_spurious();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
